// File: rtl/apb_master_bridge_if.sv
// Request/response and APB bus signals of the bridge, bundled.
// master: the bridge's view (it drives APB and the response).
// slave:  the opposite side (requester plus APB completer).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic [2:0]        req_prot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] out_paddr;
  logic              out_psel;
  logic              out_penable;
  logic [2:0]        out_pprot;
  logic              out_pwrite;
  logic [31:0]       out_pwdata;
  logic [3:0]        out_pstrb;
  logic              out_pready;
  logic [31:0]       out_prdata;
  logic              out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready request becomes one APB SETUP+ACCESS
// transfer; the result is held as a response until consumed. ACCESS can be
// aborted after TIMEOUT cycles (TIMEOUT=0 waits forever).
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  apb_master_bridge_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Only combinational output; forced low while reset is held.
  assign bus.req_ready   = (state_q == IDLE) && !reset;

  assign bus.out_paddr   = paddr_q;
  assign bus.out_psel    = psel_q;
  assign bus.out_penable = penable_q;
  assign bus.out_pprot   = pprot_q;
  assign bus.out_pwrite  = pwrite_q;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          // Strobes carry no meaning on reads; keep them quiet on the bus.
          pstrb_d  = bus.req_write ? bus.req_wstrb : 4'h0;
          pprot_d  = bus.req_prot;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completer answering on the abort cycle still wins.
        if (bus.out_pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : bus.out_prdata;
          rsp_err_d     = bus.out_pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any transfer in flight immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pprot_q       <= 3'h0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= 32'h0;
      pstrb_q       <= 4'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=8).
module tb_apb_master_bridge;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  apb_master_bridge_if #(.ADDR_W(32)) bus();

  apb_master_bridge #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; land 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request and take the handshake edge; afterwards in SETUP.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    bus.req_prot  = p;
    chk("req_ready_idle", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
  endtask

  // Consume a pending response.
  task automatic consume();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", bus.rsp_valid, 0);
  endtask

  initial begin
    int n;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_write   = 1'b0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.req_prot    = '0;
    bus.rsp_ready   = 1'b0;
    bus.out_pready  = 1'b0;
    bus.out_prdata  = '0;
    bus.out_pslverr = 1'b0;

    // Reset state
    step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_psel", bus.out_psel, 0);
    chk("rst_penable", bus.out_penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.out_paddr, 0);
    reset = 1'b0;
    step();
    chk("req_ready_after_rst", bus.req_ready, 1);

    // 1: write, immediate pready
    bus.out_pready = 1'b1;
    send(32'h8, 1'b1, 32'h0000_1234, 4'hF, 3'b010);
    chk("t1_setup_psel", bus.out_psel, 1);
    chk("t1_setup_penable", bus.out_penable, 0);
    chk("t1_setup_req_ready", bus.req_ready, 0);
    chk("t1_paddr", bus.out_paddr, 32'h8);
    chk("t1_pwrite", bus.out_pwrite, 1);
    chk("t1_pwdata", bus.out_pwdata, 32'h1234);
    chk("t1_pstrb", bus.out_pstrb, 4'hF);
    chk("t1_pprot", bus.out_pprot, 3'b010);
    step();
    chk("t1_access_psel", bus.out_psel, 1);
    chk("t1_access_penable", bus.out_penable, 1);
    step();
    bus.out_pready = 1'b0;
    chk("t1_rsp_psel", bus.out_psel, 0);
    chk("t1_rsp_penable", bus.out_penable, 0);
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_err", bus.rsp_err, 0);
    chk("t1_rsp_rdata", bus.rsp_rdata, 0);
    chk("t1_rsp_req_ready", bus.req_ready, 0);
    consume();

    // 2: read with 3 wait states
    send(32'h4, 1'b0, 32'hDEAD_BEEF, 4'hF, 3'b000);
    chk("t2_pstrb", bus.out_pstrb, 4'h0);
    chk("t2_pwrite", bus.out_pwrite, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.out_pready = 1'b1;
        bus.out_prdata = 32'h0000_A5A5;
      end
      chk("t2_paddr_stable", bus.out_paddr, 32'h4);
      chk("t2_pwrite_stable", bus.out_pwrite, 0);
      chk("t2_penable", bus.out_penable, 1);
      chk("t2_rsp_valid_low", bus.rsp_valid, 0);
      step();
    end
    bus.out_pready = 1'b0;
    bus.out_prdata = 32'h0;
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_rdata", bus.rsp_rdata, 32'h0000_A5A5);
    chk("t2_rsp_err", bus.rsp_err, 0);
    consume();

    // 3: timeout after 8 ACCESS cycles
    bus.out_prdata = 32'h1111_2222;
    send(32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
    step();
    n = 0;
    while (bus.out_penable && n < 20) begin
      n++;
      step();
    end
    chk("t3_access_cycles", n, 8);
    chk("t3_psel", bus.out_psel, 0);
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rsp_err", bus.rsp_err, 1);
    chk("t3_rsp_timeout", bus.rsp_timeout, 1);
    chk("t3_rsp_rdata", bus.rsp_rdata, 0);
    bus.out_prdata = 32'h0;
    consume();

    // 4: slave error on write, then a normal read
    bus.out_pready  = 1'b1;
    bus.out_pslverr = 1'b1;
    send(32'hC, 1'b1, 32'h5, 4'h1, 3'b000);
    step();
    step();
    bus.out_pslverr = 1'b0;
    chk("t4_rsp_valid", bus.rsp_valid, 1);
    chk("t4_rsp_err", bus.rsp_err, 1);
    chk("t4_rsp_timeout", bus.rsp_timeout, 0);
    consume();
    bus.out_prdata = 32'h0000_0055;
    send(32'h14, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    step();
    chk("t4b_rsp_rdata", bus.rsp_rdata, 32'h55);
    chk("t4b_rsp_err", bus.rsp_err, 0);
    consume();

    // 5: response backpressure with a second request waiting
    bus.out_prdata = 32'h0000_7777;
    send(32'h18, 1'b0, 32'h0, 4'h0, 3'b000);
    step();
    step();
    bus.out_pready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_write  = 1'b1;
    bus.req_wdata  = 32'h9;
    bus.req_wstrb  = 4'h3;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_valid_held", bus.rsp_valid, 1);
      chk("t5_rsp_rdata_held", bus.rsp_rdata, 32'h7777);
      chk("t5_req_ready_low", bus.req_ready, 0);
      chk("t5_no_setup", bus.out_psel, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t5_idle_rsp_valid", bus.rsp_valid, 0);
    chk("t5_idle_psel", bus.out_psel, 0);
    chk("t5_idle_req_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    chk("t5_setup_psel", bus.out_psel, 1);
    chk("t5_setup_penable", bus.out_penable, 0);
    chk("t5_setup_paddr", bus.out_paddr, 32'h20);
    bus.out_pready = 1'b1;
    step();
    step();
    bus.out_pready = 1'b0;
    chk("t5_second_rsp", bus.rsp_valid, 1);
    consume();

    // 6: reset during ACCESS
    send(32'h24, 1'b1, 32'hABCD, 4'hF, 3'b000);
    step();
    chk("t6_in_access", bus.out_penable, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_psel", bus.out_psel, 0);
    chk("t6_async_penable", bus.out_penable, 0);
    chk("t6_req_ready_in_rst", bus.req_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("t6_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_rsp", bus.rsp_valid, 0);
      chk("t6_no_psel", bus.out_psel, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
